// File: rtl/tot_trigger_pkg.sv
// Shared types and helpers for the TOT event trigger: FSM encoding, record layout, saturating math.
package tot_trigger_pkg;

    localparam int unsigned TOT_W   = 16;
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Record is {time, peak, width}; width and peak occupy the low 32 bits.
    function automatic int unsigned rec_w(input int unsigned ts_w);
        return ts_w + 32;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == SAT_MAX) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Register-based first-word-fall-through FIFO with a registered head; a push on a full FIFO
// is accepted only when a pop happens in the same cycle.
module event_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_drop_c
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          r_valid;
    logic [W-1:0]  r_head;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_left;
    logic [AW-1:0] w_rd_nxt;
    logic [W-1:0]  w_head_nxt;

    // Head of the next cycle: the pushed word when it lands in an otherwise empty FIFO.
    always_comb begin
        w_pop      = i_pop && r_valid;
        w_push     = i_push && (!r_full || w_pop);
        w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
        w_left     = r_cnt - CW'(w_pop);
        w_rd_nxt   = w_pop ? r_rd + AW'(1) : r_rd;
        w_head_nxt = '0;
        if (w_cnt_nxt != '0) begin
            if (w_left == '0) begin
                w_head_nxt = i_data;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    assign o_drop_c = i_push && r_full && !w_pop;
    assign o_valid  = r_valid;
    assign o_data   = r_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            r_valid <= (w_cnt_nxt != '0);
            r_head  <= w_head_nxt;
        end
    end

endmodule

// File: rtl/tot_event_trigger.sv
// Threshold trigger on the rolling TOT count: opens an event, tracks peak and width,
// queues a timestamped record on close, then applies a programmable dead-time.
module tot_event_trigger
    import tot_trigger_pkg::*;
#(
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ENABLE,
    input  logic [15:0]         TOTIN,
    input  logic [15:0]         THRESHOLD,
    input  logic [15:0]         HOLDOFF,
    output logic                EVT_VALID,
    input  logic                EVT_READY,
    output logic [TS_WIDTH-1:0] EVT_TIME,
    output logic [15:0]         EVT_PEAK,
    output logic [15:0]         EVT_WIDTH,
    output logic [15:0]         DROPCOUNT,
    output logic                BUSY
);
    localparam int unsigned REC_W = rec_w(TS_WIDTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_ts_q;
    logic [TS_WIDTH-1:0] r_time;
    logic [TOT_W-1:0]    r_tot_q;
    logic [TOT_W-1:0]    r_peak;
    logic [TOT_W-1:0]    r_width;
    logic [TOT_W-1:0]    r_hcnt;
    logic [TOT_W-1:0]    r_drop;
    logic                r_busy;

    logic                w_above;
    logic                w_open;
    logic                w_track;
    logic                w_push;
    logic                w_hload;
    logic                w_hdec;
    logic                w_drop_c;
    logic [REC_W-1:0]    w_rec;
    logic [REC_W-1:0]    w_head;

    assign w_above = (THRESHOLD != '0) && (r_tot_q >= THRESHOLD);

    // Input stage and free-running timestamp.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ts    <= '0;
            r_ts_q  <= '0;
            r_tot_q <= '0;
        end else begin
            r_ts    <= r_ts + TS_WIDTH'(1);
            r_ts_q  <= r_ts;
            r_tot_q <= TOTIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ENABLE && w_above) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!w_above) begin
                    w_state_nxt = (HOLDOFF == '0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (r_hcnt == 16'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_open  = 1'b0;
        w_track = 1'b0;
        w_push  = 1'b0;
        w_hload = 1'b0;
        w_hdec  = 1'b0;
        case (r_state)
            ST_IDLE:    w_open = ENABLE && w_above;
            ST_ACTIVE: begin
                w_track = w_above;
                w_push  = !w_above;
                w_hload = !w_above && (HOLDOFF != '0);
            end
            ST_HOLDOFF: w_hdec = 1'b1;
            default:    w_open = 1'b0;
        endcase
    end

    // Event tracking and dead-time counter; HOLDOFF is captured only when the event closes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_time  <= '0;
            r_peak  <= '0;
            r_width <= '0;
            r_hcnt  <= '0;
        end else begin
            if (w_open) begin
                r_time  <= r_ts_q;
                r_peak  <= r_tot_q;
                r_width <= 16'd1;
            end else if (w_track) begin
                r_peak  <= max16(r_peak, r_tot_q);
                r_width <= sat_inc(r_width);
            end
            if (w_hload) begin
                r_hcnt <= HOLDOFF;
            end else if (w_hdec) begin
                r_hcnt <= r_hcnt - 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_busy <= 1'b0;
            r_drop <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_drop_c) begin
                r_drop <= sat_inc(r_drop);
            end
        end
    end

    assign w_rec = {r_time, r_peak, r_width};

    event_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .i_push   (w_push),
        .i_data   (w_rec),
        .i_pop    (EVT_READY),
        .o_valid  (EVT_VALID),
        .o_data   (w_head),
        .o_drop_c (w_drop_c)
    );

    assign EVT_TIME  = w_head[REC_W-1 -: TS_WIDTH];
    assign EVT_PEAK  = w_head[31:16];
    assign EVT_WIDTH = w_head[15:0];
    assign DROPCOUNT = r_drop;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_tot_event_trigger.sv
// Bench for tot_event_trigger: 32-bit and 8-bit timestamp builds share stimulus and are
// checked every cycle against an event-level reference model plus pinned literal expectations.
module tb_tot_event_trigger;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic        EVT_READY;
    logic [15:0] TOTIN;
    logic [15:0] THRESHOLD;
    logic [15:0] HOLDOFF;

    logic        v32, v8, b32, b8;
    logic [31:0] t32;
    logic [7:0]  t8;
    logic [15:0] p32, w32, d32, p8, w8, d8;

    always #5 CLK = ~CLK;

    tot_event_trigger #(.TS_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut32 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .TOTIN(TOTIN),
        .THRESHOLD(THRESHOLD), .HOLDOFF(HOLDOFF), .EVT_VALID(v32), .EVT_READY(EVT_READY),
        .EVT_TIME(t32), .EVT_PEAK(p32), .EVT_WIDTH(w32), .DROPCOUNT(d32), .BUSY(b32)
    );

    tot_event_trigger #(.TS_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut8 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .TOTIN(TOTIN),
        .THRESHOLD(THRESHOLD), .HOLDOFF(HOLDOFF), .EVT_VALID(v8), .EVT_READY(EVT_READY),
        .EVT_TIME(t8), .EVT_PEAK(p8), .EVT_WIDTH(w8), .DROPCOUNT(d8), .BUSY(b8)
    );

    typedef struct {
        int unsigned t;
        logic [15:0] peak;
        logic [15:0] width;
    } rec_t;

    // Reference model: edge index, event in progress, first edge allowed to re-open, record queue.
    rec_t        q[$];
    rec_t        m_ev;
    int unsigned m_edge;
    int unsigned m_rdy_edge;
    int unsigned m_prev_ts;
    logic [15:0] m_prev_tot;
    logic [15:0] m_drop;
    bit          m_open;
    bit          m_busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [15:0] seq [8] = '{16'd0, 16'd0, 16'd5, 16'd7, 16'd9, 16'd6, 16'd4, 16'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, input logic [15:0] tot, input logic [15:0] thr,
                              input logic [15:0] hold, input logic rdy);
        bit above;
        above = (thr != 16'd0) && (m_prev_tot >= thr);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (m_open) begin
            if (above) begin
                if (m_prev_tot > m_ev.peak) m_ev.peak = m_prev_tot;
                if (m_ev.width != 16'hFFFF) m_ev.width = m_ev.width + 16'd1;
            end else begin
                if (q.size() >= int'(DEPTH)) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    q.push_back(m_ev);
                end
                m_open     = 1'b0;
                m_rdy_edge = m_edge + int'(hold) + 1;
            end
        end else if (m_edge >= m_rdy_edge && en && above) begin
            m_open     = 1'b1;
            m_ev.t     = m_prev_ts;
            m_ev.peak  = m_prev_tot;
            m_ev.width = 16'd1;
        end
        m_busy     = m_open || (m_edge + 1 < m_rdy_edge);
        m_prev_tot = tot;
        m_prev_ts  = m_edge;
        m_edge++;
    endtask

    task automatic step(input logic [15:0] tot, input logic en, input logic rdy);
        TOTIN     = tot;
        ENABLE    = en;
        EVT_READY = rdy;
        @(posedge CLK);
        #1;
        model_edge(en, tot, THRESHOLD, HOLDOFF, rdy);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        chk("rst_valid", 64'(v32), 64'd0);
        chk("rst_time", 64'(t32), 64'd0);
        chk("rst_peak", 64'(p32), 64'd0);
        chk("rst_width", 64'(w32), 64'd0);
        chk("rst_drop", 64'(d32), 64'd0);
        chk("rst_busy", 64'(b32), 64'd0);
        chk("rst_valid8", 64'(v8), 64'd0);
        chk("rst_busy8", 64'(b8), 64'd0);
        q.delete();
        m_open = 1'b0; m_busy = 1'b0; m_edge = 0; m_rdy_edge = 0;
        m_prev_ts = 0; m_prev_tot = 16'd0; m_drop = 16'd0;
        @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        chk_en  = 1'b1;
    endtask

    // Per-cycle comparison of both builds against the model, plus head stability under stall.
    logic        st_prev = 1'b0;
    logic [31:0] s_t;
    logic [15:0] s_p, s_w;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            st_prev = 1'b0;
        end else if (chk_en) begin
            chk("valid", 64'(v32), 64'(q.size() != 0));
            chk("valid8", 64'(v8), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("time", 64'(t32), 64'(q[0].t));
                chk("time8", 64'(t8), 64'(q[0].t % 256));
                chk("peak", 64'(p32), 64'(q[0].peak));
                chk("width", 64'(w32), 64'(q[0].width));
                chk("peak8", 64'(p8), 64'(q[0].peak));
                chk("width8", 64'(w8), 64'(q[0].width));
            end
            chk("drop", 64'(d32), 64'(m_drop));
            chk("drop8", 64'(d8), 64'(m_drop));
            chk("busy", 64'(b32), 64'(m_busy));
            chk("busy8", 64'(b8), 64'(m_busy));
            if (st_prev) begin
                chk("stall_time", 64'(t32), 64'(s_t));
                chk("stall_peak", 64'(p32), 64'(s_p));
                chk("stall_width", 64'(w32), 64'(s_w));
            end
            st_prev = v32 && !EVT_READY;
            s_t = t32;
            s_p = p32;
            s_w = w32;
        end
    end

    initial begin
        RESET_N   = 1'b1;
        ENABLE    = 1'b1;
        EVT_READY = 1'b0;
        TOTIN     = 16'd0;
        THRESHOLD = 16'd5;
        HOLDOFF   = 16'd0;
        #2;
        do_reset();

        // Basic event: samples 10..17 = 0,0,5,7,9,6,4,0.
        for (int idx = 0; idx < 18; idx++) begin
            step((idx >= 10) ? seq[idx-10] : 16'd0, 1'b1, 1'b0);
            chk("basic_busy", 64'(b32), 64'(idx >= 13 && idx <= 16));
            chk("basic_valid", 64'(v32), 64'(idx >= 17));
        end
        chk("basic_time", 64'(t32), 64'd12);
        chk("basic_peak", 64'(p32), 64'd9);
        chk("basic_width", 64'(w32), 64'd4);
        step(16'd0, 1'b1, 1'b1);

        // THRESHOLD=0 never triggers.
        THRESHOLD = 16'd0;
        for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        chk("thr0_valid", 64'(v32), 64'd0);
        chk("thr0_busy", 64'(b32), 64'd0);

        // ENABLE low in IDLE suppresses the event.
        THRESHOLD = 16'd5;
        for (int i = 0; i < 3; i++) step(16'd9, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0);
        chk("en0_valid", 64'(v32), 64'd0);

        // ENABLE dropped mid-event: record still emitted.
        step(16'd8, 1'b1, 1'b0);
        step(16'd9, 1'b1, 1'b0);
        step(16'd6, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0);
        step(16'd0, 1'b0, 1'b0);
        chk("endrop_valid", 64'(v32), 64'd1);
        chk("endrop_peak", 64'(p32), 64'd9);
        chk("endrop_width", 64'(w32), 64'd3);
        step(16'd0, 1'b1, 1'b1);

        // Holdoff 3: separation of 2 drops the second pulse, separation of 4 keeps it.
        HOLDOFF = 16'd3;
        step(16'd9, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd11, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(16'd0, 1'b1, 1'b0);
        chk("hold2_peak", 64'(p32), 64'd9);
        step(16'd0, 1'b1, 1'b1);
        chk("hold2_empty", 64'(v32), 64'd0);
        step(16'd12, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(16'd0, 1'b1, 1'b0);
        step(16'd13, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(16'd0, 1'b1, 1'b0);
        chk("hold4_first", 64'(p32), 64'd12);
        step(16'd0, 1'b1, 1'b1);
        chk("hold4_second", 64'(p32), 64'd13);
        step(16'd0, 1'b1, 1'b1);
        chk("hold4_empty", 64'(v32), 64'd0);

        // Overflow: 6 pulses into a 4-deep FIFO, then push with simultaneous pop on full.
        HOLDOFF = 16'd0;
        for (int k = 0; k < 6; k++) begin
            step(16'(20 + k), 1'b1, 1'b0);
            step(16'd0, 1'b1, 1'b0);
        end
        step(16'd0, 1'b1, 1'b0);
        chk("ovf_drop", 64'(d32), 64'd2);
        chk("ovf_head", 64'(p32), 64'd20);
        step(16'd30, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b1);
        chk("ovf_pushpop_drop", 64'(d32), 64'd2);
        chk("ovf_pushpop_head", 64'(p32), 64'd21);
        for (int i = 0; i < 4; i++) step(16'd0, 1'b1, 1'b1);
        chk("ovf_drained", 64'(v32), 64'd0);

        // Reset mid-event with two records queued.
        step(16'd9, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd10, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(16'd12, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(16'd0, 1'b1, 1'b0);
        chk("rst_noevent", 64'(v32), 64'd0);

        // Timestamp wrap on the 8-bit build: event at T=255, then at T=258.
        while (m_edge < 255) step(16'd0, 1'b1, 1'b0);
        step(16'd9, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        chk("wrap_t8", 64'(t8), 64'd255);
        chk("wrap_t32", 64'(t32), 64'd255);
        step(16'd9, 1'b1, 1'b1);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        chk("wrap2_t8", 64'(t8), 64'd2);
        chk("wrap2_t32", 64'(t32), 64'd258);
        step(16'd0, 1'b1, 1'b1);

        // Width saturation over 70000 above-threshold samples.
        for (int i = 0; i < 70000; i++) step(16'(5 + $urandom_range(0, 3)), 1'b1, 1'b1);
        step(16'd0, 1'b1, 1'b0);
        step(16'd0, 1'b1, 1'b0);
        chk("sat_width", 64'(w32), 64'hFFFF);
        chk("sat_width8", 64'(w8), 64'hFFFF);
        step(16'd0, 1'b1, 1'b1);

        // Randomized events with back-pressure, enable dropouts and varying holdoff.
        for (int ev = 0; ev < 200; ev++) begin
            int unsigned gap, len;
            THRESHOLD = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 1000));
            HOLDOFF   = 16'($urandom_range(0, 4));
            gap = $urandom_range(0, 6);
            len = $urandom_range(1, 5);
            for (int i = 0; i < int'(gap); i++)
                step((THRESHOLD == 16'd0) ? 16'($urandom) : 16'($urandom_range(0, 32'(THRESHOLD) - 1)),
                     ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'(len); i++)
                step((THRESHOLD == 16'd0) ? 16'hFFFF : 16'($urandom_range(32'(THRESHOLD), 65535)),
                     ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10; i++) step(16'd0, 1'b1, 1'b1);
        chk("final_empty", 64'(v32), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
